plugboard_stage: RTL and testbench

- Upstream neighbour of the first rotor: takes one ASCII character per keypress, applies the programmable Enigma plugboard letter swaps, and presents the result on plug_board.
- Generates the single-cycle signal strobe that clocks the first rotor's stepping counter and mapping.
- Holds up to NUM_PAIRS swap pairs, loaded through a small config port.
- Upper and lower case share the same pairs; non-letters pass through unchanged.

---
 rtl/enigma_pkg.sv | 39 +++
 rtl/plug_pair_table.sv | 114 +++++++++++
 rtl/plugboard_stage.sv | 160 ++++++++++++++++
 tb/tb_plugboard_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared Enigma definitions: ASCII anchors, letter-index type, plugboard FSM
// states and the character/letter conversion helpers.
package enigma_pkg;

   localparam logic [15:0] ASCII_A  = 16'd65;
   localparam logic [15:0] ASCII_LA = 16'd97;
   localparam int          ALPHA_N  = 26;

   typedef logic [4:0] letter_t;

   localparam letter_t LETTER_MAX = letter_t'(ALPHA_N - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_OUT,
      ST_STROBE
   } plug_state_t;

   function automatic logic is_upper(input logic [15:0] c);
      return (c >= ASCII_A) && (c < ASCII_A + 16'(ALPHA_N));
   endfunction

   function automatic logic is_lower(input logic [15:0] c);
      return (c >= ASCII_LA) && (c < ASCII_LA + 16'(ALPHA_N));
   endfunction

   // Only meaningful when the code is a letter of either case.
   function automatic letter_t to_idx(input logic [15:0] c);
      logic [15:0] off;
      off = is_lower(c) ? (c - ASCII_LA) : (c - ASCII_A);
      return letter_t'(off);
   endfunction

   function automatic logic [15:0] to_ascii(input letter_t idx, input logic lower);
      return (lower ? ASCII_LA : ASCII_A) + {11'd0, idx};
   endfunction

endpackage

// File: rtl/plug_pair_table.sv
// Swap-pair slot storage for the plugboard.
// Ports:
//   clk, rst        clock, synchronous active-low reset (clears all slots)
//   idle            high while the owning FSM is in IDLE; config only lands then
//   cfg_wr/cfg_clr  slot write / clear-all requests
//   cfg_idx/en/a/b  slot number, enable and the two letter indices
//   cfg_err         one-cycle pulse after a rejected request
//   rd_idx -> rd_en, rd_a, rd_b   combinational slot read for the scanner
module plug_pair_table
   import enigma_pkg::*;
#(
   parameter int NUM_PAIRS = 10,
   parameter int IDX_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             idle,
   input  logic             cfg_wr,
   input  logic             cfg_clr,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic             cfg_en,
   input  letter_t          cfg_a,
   input  letter_t          cfg_b,
   output logic             cfg_err,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_en,
   output letter_t          rd_a,
   output letter_t          rd_b
);

   logic [NUM_PAIRS-1:0] en_q, en_d;
   letter_t              a_q [NUM_PAIRS];
   letter_t              a_d [NUM_PAIRS];
   letter_t              b_q [NUM_PAIRS];
   letter_t              b_d [NUM_PAIRS];
   logic                 cfg_err_q, cfg_err_d;

   logic idx_bad;
   logic pair_bad;
   logic conflict;

   // A letter may live in only one enabled slot; the slot being rewritten
   // does not count against itself.
   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
         if (en_q[i] && (IDX_W'(i) != cfg_idx) &&
             (a_q[i] == cfg_a || a_q[i] == cfg_b ||
              b_q[i] == cfg_a || b_q[i] == cfg_b))
            conflict = 1'b1;
      end
   end

   assign idx_bad  = int'(cfg_idx) >= NUM_PAIRS;
   assign pair_bad = (cfg_a == cfg_b) || (cfg_a > LETTER_MAX) ||
                     (cfg_b > LETTER_MAX) || conflict;

   always_comb begin
      en_d      = en_q;
      a_d       = a_q;
      b_d       = b_q;
      cfg_err_d = 1'b0;
      if (cfg_clr) begin
         if (idle) en_d = '0;
         else      cfg_err_d = 1'b1;
      end else if (cfg_wr) begin
         if (!idle || idx_bad || (cfg_en && pair_bad)) begin
            cfg_err_d = 1'b1;
         end else begin
            for (int i = 0; i < NUM_PAIRS; i++) begin
               if (IDX_W'(i) == cfg_idx) begin
                  en_d[i] = cfg_en;
                  if (cfg_en) begin
                     a_d[i] = cfg_a;
                     b_d[i] = cfg_b;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         en_q      <= '0;
         cfg_err_q <= 1'b0;
         for (int i = 0; i < NUM_PAIRS; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
      end else begin
         en_q      <= en_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   always_comb begin
      rd_en = 1'b0;
      rd_a  = '0;
      rd_b  = '0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
         if (IDX_W'(i) == rd_idx) begin
            rd_en = en_q[i];
            rd_a  = a_q[i];
            rd_b  = b_q[i];
         end
      end
   end

   assign cfg_err = cfg_err_q;

endmodule

// File: rtl/plugboard_stage.sv
// Enigma plugboard ahead of the first rotor: accepts one ASCII character,
// swaps it through the programmed letter pairs and strobes the rotor.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   char_in/valid/ready      character handshake (ready only in IDLE)
//   cfg_*                    pair-table configuration, see plug_pair_table
//   plug_board/plug_valid    swapped character, one-cycle update pulse
//   signal                   rotor strobe, the cycle after plug_valid
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a character, config writes accepted
// ST_SCAN   | walking slots 0..NUM_PAIRS-1, one per cycle
// ST_OUT    | registering the result onto plug_board
// ST_STROBE | registering the rotor strobe
module plugboard_stage
   import enigma_pkg::*;
#(
   parameter int NUM_PAIRS = 10,
   parameter int IDX_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      char_in,
   input  logic             char_valid,
   output logic             char_ready,
   input  logic             cfg_wr,
   input  logic             cfg_clr,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic             cfg_en,
   input  logic [4:0]       cfg_a,
   input  logic [4:0]       cfg_b,
   output logic             cfg_err,
   output logic [15:0]      plug_board,
   output logic             plug_valid,
   output logic             signal
);

   localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_PAIRS - 1);

   plug_state_t      state_q, state_d;
   logic [15:0]      result_q, result_d;
   letter_t          letter_q, letter_d;
   logic             is_let_q, is_let_d;
   logic             lower_q, lower_d;
   logic             found_q, found_d;
   logic [IDX_W-1:0] scan_left_q, scan_left_d;
   logic [15:0]      plug_board_q, plug_board_d;
   logic             plug_valid_q, plug_valid_d;
   logic             signal_q, signal_d;

   logic             rd_en;
   letter_t          rd_a, rd_b;
   logic [IDX_W-1:0] rd_idx;

   // Remaining-slot down-counter; slots are still visited in ascending order.
   assign rd_idx = LAST_SLOT - scan_left_q;

   plug_pair_table #(
      .NUM_PAIRS (NUM_PAIRS),
      .IDX_W     (IDX_W)
   ) u_table (
      .clk     (clk),
      .rst     (rst),
      .idle    (state_q == ST_IDLE),
      .cfg_wr  (cfg_wr),
      .cfg_clr (cfg_clr),
      .cfg_idx (cfg_idx),
      .cfg_en  (cfg_en),
      .cfg_a   (cfg_a),
      .cfg_b   (cfg_b),
      .cfg_err (cfg_err),
      .rd_idx  (rd_idx),
      .rd_en   (rd_en),
      .rd_a    (rd_a),
      .rd_b    (rd_b)
   );

   always_comb begin
      state_d      = state_q;
      result_d     = result_q;
      letter_d     = letter_q;
      is_let_d     = is_let_q;
      lower_d      = lower_q;
      found_d      = found_q;
      scan_left_d  = scan_left_q;
      plug_board_d = plug_board_q;
      plug_valid_d = 1'b0;
      signal_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (char_valid) begin
               result_d    = char_in;
               letter_d    = to_idx(char_in);
               is_let_d    = is_upper(char_in) || is_lower(char_in);
               lower_d     = is_lower(char_in);
               found_d     = 1'b0;
               scan_left_d = LAST_SLOT;
               state_d     = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // Matching is on the original letter, so a swap never re-matches.
            if (rd_en && is_let_q && !found_q) begin
               if (rd_a == letter_q) begin
                  result_d = to_ascii(rd_b, lower_q);
                  found_d  = 1'b1;
               end else if (rd_b == letter_q) begin
                  result_d = to_ascii(rd_a, lower_q);
                  found_d  = 1'b1;
               end
            end
            if (scan_left_q == '0) state_d = ST_OUT;
            else                   scan_left_d = scan_left_q - 1'b1;
         end
         ST_OUT: begin
            plug_board_d = result_q;
            plug_valid_d = 1'b1;
            state_d      = ST_STROBE;
         end
         ST_STROBE: begin
            signal_d = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         result_q     <= '0;
         letter_q     <= '0;
         is_let_q     <= 1'b0;
         lower_q      <= 1'b0;
         found_q      <= 1'b0;
         scan_left_q  <= '0;
         plug_board_q <= '0;
         plug_valid_q <= 1'b0;
         signal_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         result_q     <= result_d;
         letter_q     <= letter_d;
         is_let_q     <= is_let_d;
         lower_q      <= lower_d;
         found_q      <= found_d;
         scan_left_q  <= scan_left_d;
         plug_board_q <= plug_board_d;
         plug_valid_q <= plug_valid_d;
         signal_q     <= signal_d;
      end
   end

   assign char_ready = (state_q == ST_IDLE);
   assign plug_board = plug_board_q;
   assign plug_valid = plug_valid_q;
   assign signal     = signal_q;

endmodule

// File: tb/tb_plugboard_stage.sv
module tb_plugboard_stage;
   localparam int N  = 10;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   char_in;
   logic          char_valid;
   logic          char_ready;
   logic          cfg_wr, cfg_clr, cfg_en;
   logic [IW-1:0] cfg_idx;
   logic [4:0]    cfg_a, cfg_b;
   logic          cfg_err;
   logic [15:0]   plug_board;
   logic          plug_valid;
   logic          signal;

   always #5 clk = ~clk;

   plugboard_stage #(.NUM_PAIRS(N), .IDX_W(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .cfg_wr     (cfg_wr),
      .cfg_clr    (cfg_clr),
      .cfg_idx    (cfg_idx),
      .cfg_en     (cfg_en),
      .cfg_a      (cfg_a),
      .cfg_b      (cfg_b),
      .cfg_err    (cfg_err),
      .plug_board (plug_board),
      .plug_valid (plug_valid),
      .signal     (signal)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the slot table as plain arrays, and the in-flight
   // character as "cycles since its transfer" (phase, -1 when none).
   bit          m_en [N];
   int          m_a  [N];
   int          m_b  [N];
   int          phase     = -1;
   int          m_res     = 0;
   int          e_pb      = 0;
   int          e_err     = 0;
   bit          chk_en    = 0;
   int          sig_count = 0;
   int          cyc       = 0;

   function automatic int plug(input int c);
      int l;
      int base;
      if (c >= 65 && c <= 90) begin
         l = c - 65; base = 65;
      end else if (c >= 97 && c <= 122) begin
         l = c - 97; base = 97;
      end else begin
         return c;
      end
      for (int i = 0; i < N; i++) begin
         if (m_en[i] && m_a[i] == l) return base + m_b[i];
         if (m_en[i] && m_b[i] == l) return base + m_a[i];
      end
      return c;
   endfunction

   task automatic model_step();
      bit idle, dup, err;
      int ia, ib, ix;
      if (!rst) begin
         for (int i = 0; i < N; i++) m_en[i] = 0;
         phase = -1; e_pb = 0; e_err = 0;
         return;
      end
      idle = (phase < 0 || phase >= N + 2);
      ia = int'(cfg_a); ib = int'(cfg_b); ix = int'(cfg_idx);
      err = 0;
      if (cfg_clr) begin
         if (idle) for (int i = 0; i < N; i++) m_en[i] = 0;
         else      err = 1;
      end else if (cfg_wr) begin
         dup = 0;
         for (int i = 0; i < N; i++)
            if (i != ix && m_en[i] &&
                (m_a[i] == ia || m_a[i] == ib || m_b[i] == ia || m_b[i] == ib))
               dup = 1;
         if (!idle || ix >= N || (cfg_en && (ia == ib || ia > 25 || ib > 25 || dup))) begin
            err = 1;
         end else begin
            m_en[ix] = cfg_en;
            if (cfg_en) begin m_a[ix] = ia; m_b[ix] = ib; end
         end
      end
      e_err = err ? 1 : 0;
      if (phase >= 0) phase++;
      if (phase > N + 2) phase = -1;
      if (idle && char_valid) begin
         phase = 0;
         m_res = plug(int'(char_in));
      end
      if (phase == N + 1) e_pb = m_res;
   endtask

   // Per-cycle compare against the model, then advance the model with the
   // inputs the DUT will sample at the coming rising edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("char_ready", 32'(char_ready), (phase < 0 || phase >= N + 2) ? 1 : 0);
         check("plug_valid", 32'(plug_valid), (phase == N + 1) ? 1 : 0);
         check("signal",     32'(signal),     (phase == N + 2) ? 1 : 0);
         check("plug_board", 32'(plug_board), e_pb);
         check("cfg_err",    32'(cfg_err),    e_err);
      end
      if (signal) sig_count++;
      cyc++;
      model_step();
      chk_en = 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int idx, input bit en, input int a, input int b,
                            input int exp_err, input string name);
      cfg_wr = 1; cfg_idx = IW'(idx); cfg_en = en; cfg_a = 5'(a); cfg_b = 5'(b);
      tick();
      cfg_wr = 0;
      check(name, 32'(cfg_err), exp_err);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!char_ready && n < 100) begin tick(); n++; end
      if (n >= 100) check("ready_timeout", 0, 1);
   endtask

   task automatic wait_plug(output int n);
      n = 0;
      while (!plug_valid && n < 100) begin tick(); n++; end
   endtask

   task automatic send_char(input int c, input int exp, input string name);
      int n;
      wait_ready();
      char_in = 16'(c); char_valid = 1;
      tick();
      char_valid = 0;
      wait_plug(n);
      check({name, "_latency"}, n, N + 1);
      check({name, "_out"}, 32'(plug_board), exp);
      tick();
      check({name, "_signal"}, 32'(signal), 1);
      check({name, "_hold"}, 32'(plug_board), exp);
      tick();
      check({name, "_signal_end"}, 32'(signal), 0);
   endtask

   int n;
   int s0;
   int tx [3];
   int edge_codes [8];

   initial begin
      edge_codes = '{64, 91, 96, 123, 65, 90, 97, 122};
      rst = 0; char_in = 0; char_valid = 0;
      cfg_wr = 0; cfg_clr = 0; cfg_en = 0; cfg_idx = 0; cfg_a = 0; cfg_b = 0;
      repeat (3) tick();
      check("rst_plug_board", 32'(plug_board), 0);
      check("rst_char_ready", 32'(char_ready), 1);
      check("rst_plug_valid", 32'(plug_valid), 0);
      check("rst_signal",     32'(signal), 0);
      rst = 1;
      tick();

      cfg_write(0, 1, 0, 25, 0, "wr_AZ");
      send_char(65,  90, "A_to_Z");
      send_char(122, 97, "z_to_a");
      send_char(77,  77, "M_pass");
      send_char(63,  63, "qmark_pass");

      cfg_write(1, 1, 25, 16, 1, "wr_dup_rejected");
      send_char(81, 81, "Q_table_unchanged");
      cfg_write(0, 1, 0, 16, 0, "wr_AQ");
      send_char(81, 65, "Q_to_A");
      send_char(122, 122, "z_now_free");

      // config write while a character is in flight
      wait_ready();
      char_in = 65; char_valid = 1;
      tick();
      char_valid = 0;
      cfg_write(0, 1, 0, 1, 1, "wr_busy_rejected");
      wait_plug(n);
      check("busy_old_table", 32'(plug_board), 81);
      repeat (3) tick();

      cfg_write(N, 1, 2, 3, 1, "wr_idx_range");
      cfg_write(2, 1, 26, 3, 1, "wr_letter_range");
      cfg_write(2, 1, 4, 4, 1, "wr_same_letter");
      cfg_write(0, 0, 0, 0, 0, "wr_disable");
      send_char(65, 65, "A_disabled");
      cfg_write(0, 1, 0, 25, 0, "wr_AZ_again");

      // transfer and config write in the same IDLE cycle
      wait_ready();
      char_in = 66; char_valid = 1;
      cfg_wr = 1; cfg_idx = 1; cfg_en = 1; cfg_a = 1; cfg_b = 2;
      tick();
      char_valid = 0; cfg_wr = 0;
      check("same_cycle_cfg_err", 32'(cfg_err), 0);
      wait_plug(n);
      check("same_cycle_new_table", 32'(plug_board), 67);
      repeat (3) tick();

      // back-to-back "ABC" with char_valid held high
      s0 = sig_count;
      char_valid = 1;
      for (int i = 0; i < 3; i++) begin
         char_in = 16'(65 + i);
         wait_ready();
         tick();
         tx[i] = cyc;
         check("abc_ready_low", 32'(char_ready), 0);
      end
      char_valid = 0;
      check("abc_gap1", tx[1] - tx[0], N + 3);
      check("abc_gap2", tx[2] - tx[1], N + 3);
      repeat (N + 5) tick();
      check("abc_signals", sig_count - s0, 3);

      // reset in the middle of SCAN
      wait_ready();
      char_in = 65; char_valid = 1;
      tick();
      char_valid = 0;
      repeat (3) tick();
      rst = 0;
      tick();
      rst = 1;
      check("midrst_plug_board", 32'(plug_board), 0);
      check("midrst_char_ready", 32'(char_ready), 1);
      s0 = sig_count;
      repeat (N + 5) tick();
      check("midrst_no_signal", sig_count - s0, 0);
      send_char(65, 65, "A_after_reset");

      // randomized traffic, checked every cycle by the model
      for (int i = 0; i < 4000; i++) begin
         int r;
         rst        = ($urandom_range(0, 299) != 0);
         char_valid = ($urandom_range(0, 3) == 0);
         r = int'($urandom_range(0, 9));
         if (r < 4)       char_in = 16'(65 + $urandom_range(0, 25));
         else if (r < 8)  char_in = 16'(97 + $urandom_range(0, 25));
         else if (r == 8) char_in = 16'(edge_codes[$urandom_range(0, 7)]);
         else             char_in = 16'($urandom);
         cfg_clr = ($urandom_range(0, 79) == 0);
         cfg_wr  = ($urandom_range(0, 4) == 0);
         cfg_idx = IW'($urandom_range(0, N));
         cfg_en  = ($urandom_range(0, 4) != 0);
         cfg_a   = 5'($urandom_range(0, 27));
         cfg_b   = 5'($urandom_range(0, 27));
         tick();
      end
      rst = 1; char_valid = 0; cfg_wr = 0; cfg_clr = 0;
      repeat (N + 5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
